// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its per-requester byte FIFOs.
package uart_sched_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WBUSY = 2'd2,
    WDONE = 2'd3
  } state_e;

  // Bits needed to encode values below v, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small show-ahead byte FIFO; head byte is visible on pop_data whenever not empty.
module byte_fifo
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that drains per-requester byte FIFOs into a single UART transmitter.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUSY_WAIT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        req_overflow,
  input  logic                    ovf_clear,
  input  logic                    uart_w_ready,
  output logic                    uart_w_enable,
  output logic [BYTE_W-1:0]       uart_w_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int unsigned IDX_W  = clog2_min1(N_REQ);
  localparam int unsigned CNT_W  = clog2_min1(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_W = clog2_min1(BUSY_WAIT);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [BYTE_W-1:0]   w_data_q, w_data_d;
  logic                w_enable_q, w_enable_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [N_REQ-1:0]    ovf_q, ovf_d;

  logic [BYTE_W-1:0]   fifo_head  [N_REQ];
  logic [CNT_W-1:0]    fifo_count [N_REQ];
  logic [N_REQ-1:0]    fifo_full;
  logic [N_REQ-1:0]    fifo_empty;
  logic [N_REQ-1:0]    push_en;
  logic [N_REQ-1:0]    pop_en;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  int unsigned         scan_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    assign req_ready[i] = (fifo_count[i] < CNT_W'(FIFO_DEPTH));

    byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en[i]),
      .push_data (req_data[BYTE_W*i +: BYTE_W]),
      .pop       (pop_en[i]),
      .pop_data  (fifo_head[i]),
      .count     (fifo_count[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  assign push_en = req_valid & req_ready;

  // Sticky overflow; a new drop in the clearing cycle keeps its bit set.
  assign ovf_d = (ovf_q & ~{N_REQ{ovf_clear}}) | (req_valid & fifo_full);

  // First nonempty FIFO at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!pick_found && !fifo_empty[IDX_W'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    w_data_d   = w_data_q;
    w_enable_d = 1'b0;
    rr_d       = rr_q;
    win_d      = win_q;
    wait_d     = wait_q;
    pop_en     = '0;

    case (state_q)
      IDLE: begin
        if (pick_found && uart_w_ready) begin
          pop_en[pick_idx] = 1'b1;
          w_data_d         = fifo_head[pick_idx];
          grant_d          = N_REQ'(1) << pick_idx;
          win_d            = pick_idx;
          w_enable_d       = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WBUSY;
      end
      WBUSY: begin
        // A UART that never drops ready is treated as done after the wait window.
        if (!uart_w_ready || (wait_q == WAIT_W'(BUSY_WAIT - 1))) begin
          state_d = WDONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WDONE: begin
        if (uart_w_ready) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      w_data_q   <= '0;
      w_enable_q <= 1'b0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
      win_q      <= '0;
      wait_q     <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      w_data_q   <= w_data_d;
      w_enable_q <= w_enable_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      wait_q     <= wait_d;
      ovf_q      <= ovf_d;
    end
  end

  assign uart_w_enable = w_enable_q;
  assign uart_w_data   = w_data_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign req_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized checks of uart_tx_scheduler against a queue-based round-robin model.
module tb_uart_tx_scheduler;

  localparam int unsigned N         = 2;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned BUSY_WAIT = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [15:0]  req_data;
  logic [N-1:0] req_ready;
  logic [N-1:0] req_overflow;
  logic         ovf_clear;
  logic         uart_w_ready;
  logic         uart_w_enable;
  logic [7:0]   uart_w_data;
  logic [N-1:0] grant;
  logic         busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .N_REQ      (N),
    .FIFO_DEPTH (DEPTH),
    .BUSY_WAIT  (BUSY_WAIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .req_overflow  (req_overflow),
    .ovf_clear     (ovf_clear),
    .uart_w_ready  (uart_w_ready),
    .uart_w_enable (uart_w_enable),
    .uart_w_data   (uart_w_data),
    .grant         (grant),
    .busy          (busy)
  );

  // UART model: ready drops right after a strobe and returns ~20 cycles later.
  int         ur_cnt = 0;
  int         cyc = 0;
  bit         hold_low = 1'b0;
  bit         fast = 1'b0;
  logic [7:0] log_data [$];
  logic [1:0] log_grant [$];
  int         log_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_w_enable === 1'b1) begin
      log_data.push_back(uart_w_data);
      log_grant.push_back(grant);
      log_cyc.push_back(cyc);
      if (!fast) ur_cnt <= 21;
    end else if (ur_cnt > 0) begin
      ur_cnt <= ur_cnt - 1;
    end
  end

  assign uart_w_ready = !hold_low && (ur_cnt == 0);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-requester queues and a round-robin pointer.
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  int         m_rr = 0;
  logic [1:0] m_ovf = 2'b00;
  logic [7:0] exp_q [$];
  logic [1:0] expg_q [$];

  task automatic push(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_data  = {d1, d0};
    if (v[0]) begin
      if (mq0.size() < DEPTH) mq0.push_back(d0); else m_ovf[0] = 1'b1;
    end
    if (v[1]) begin
      if (mq1.size() < DEPTH) mq1.push_back(d1); else m_ovf[1] = 1'b1;
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic serve();
    int w;
    exp_q.delete();
    expg_q.delete();
    while (mq0.size() + mq1.size() > 0) begin
      if (m_rr == 0) w = (mq0.size() > 0) ? 0 : 1;
      else           w = (mq1.size() > 0) ? 1 : 0;
      if (w == 0) exp_q.push_back(mq0.pop_front());
      else        exp_q.push_back(mq1.pop_front());
      expg_q.push_back(2'(1 << w));
      m_rr = (w + 1) % N;
    end
  endtask

  task automatic verify(input string tag);
    int budget;
    budget = exp_q.size() * 40 + 60;
    while (log_data.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (30) @(negedge clk);
    check({tag, "_count"}, log_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_data.size(); i++) begin
      check({tag, "_data"}, log_data[i], exp_q[i]);
      check({tag, "_grant"}, log_grant[i], expg_q[i]);
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_grant_end"}, grant, 0);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_grant.delete();
    log_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int b;
    int n0;
    int n1;
    bit seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    ovf_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 2'b11);
    check("rst_ovf", req_overflow, 2'b00);
    check("rst_wen", uart_w_enable, 0);
    check("rst_wdata", uart_w_data, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_quiet", busy, 0);

    // Fairness: both requesters push on the same cycles.
    for (int k = 0; k < 4; k++) push(2'b11, 8'(16 + k), 8'(32 + k));
    check("fair_ovf", req_overflow, m_ovf);
    serve();
    verify("fair");
    clear_log();

    // Single byte and first-byte latency.
    pc = cyc;
    push(2'b01, 8'h41, 8'h00);
    b = 10;
    while (log_data.size() == 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("single_seen", log_data.size(), 1);
    check("single_latency", (log_cyc.size() > 0) ? (log_cyc[0] - pc) : -1, 2);
    check("single_grant_mid", grant, 2'b01);
    check("single_busy_mid", busy, 1);
    serve();
    verify("single");
    clear_log();

    // Overflow with UART stalled.
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) push(2'b10, 8'h00, 8'(48 + k));
    check("ovf_ready_full", req_ready[1], 0);
    check("ovf_before", req_overflow, 2'b00);
    check("ovf_no_pop", busy, 0);
    push(2'b10, 8'h00, 8'h34);
    check("ovf_set", req_overflow, m_ovf);
    ovf_clear = 1'b1;
    push(2'b10, 8'h00, 8'h35);
    ovf_clear = 1'b0;
    check("ovf_set_wins", req_overflow, m_ovf);
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    m_ovf = 2'b00;
    check("ovf_cleared", req_overflow, m_ovf);
    hold_low = 1'b0;
    serve();
    verify("ovf");
    clear_log();

    // Randomized bursts, queued while stalled then released.
    for (int r = 0; r < 3; r++) begin
      hold_low = 1'b1;
      n0 = int'($urandom_range(0, DEPTH));
      n1 = int'($urandom_range(1, DEPTH));
      for (int k = 0; k < DEPTH; k++) begin
        if (k < n0 || k < n1) push({k < n1, k < n0}, 8'($urandom), 8'($urandom));
      end
      check("rand_ovf", req_overflow, m_ovf);
      hold_low = 1'b0;
      serve();
      verify("rand");
      clear_log();
    end

    // Full FIFO refilled as soon as each pop frees a slot.
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) push(2'b01, 8'(80 + k), 8'h00);
    check("stream_full", req_ready[0], 0);
    hold_low = 1'b0;
    for (int k = 4; k < 10; k++) begin
      b = 60;
      while (req_ready[0] !== 1'b1 && b > 0) begin
        @(negedge clk);
        b--;
      end
      seen = (req_ready[0] === 1'b1);
      check("stream_slot", seen, 1);
      req_valid = 2'b01;
      req_data  = {8'h00, 8'(80 + k)};
      mq0.push_back(8'(80 + k));
      @(negedge clk);
      req_valid = '0;
      check("stream_refull", req_ready[0], 0);
    end
    check("stream_ovf", req_overflow, 2'b00);
    serve();
    verify("stream");
    clear_log();

    // UART that never drops ready: WBUSY times out.
    fast = 1'b1;
    for (int k = 0; k < 3; k++) push(2'b10, 8'h00, 8'(96 + k));
    serve();
    verify("fast");
    if (log_cyc.size() == 3) begin
      check("fast_gap1", log_cyc[1] - log_cyc[0], BUSY_WAIT + 3);
      check("fast_gap2", log_cyc[2] - log_cyc[1], BUSY_WAIT + 3);
    end else begin
      check("fast_gaps_avail", log_cyc.size(), 3);
    end
    clear_log();

    // Asynchronous reset in the middle of WBUSY.
    push(2'b11, 8'h70, 8'h71);
    b = 20;
    while (log_data.size() == 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("rstmid_started", log_data.size(), 1);
    repeat (3) @(negedge clk);
    check("rstmid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_wen", uart_w_enable, 0);
    check("rstmid_wdata", uart_w_data, 0);
    check("rstmid_grant", grant, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_ready", req_ready, 2'b11);
    check("rstmid_ovf", req_overflow, 2'b00);
    mq0.delete();
    mq1.delete();
    m_rr  = 0;
    m_ovf = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    check("rstmid_no_stray", log_data.size(), 0);
    fast = 1'b0;
    push(2'b11, 8'h80, 8'h90);
    serve();
    verify("post_rst");
    clear_log();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
